mem_stage_lsu: RTL

//  MEM-stage load/store unit on the read side of the EX/MEM pipeline register. Decodes the

---
 rtl/mem_stage_lsu_pkg.sv | 36 +++
 rtl/mem_stage_lsu_if.sv | 20 ++
 rtl/mem_byte_lane.sv | 50 +++++
 rtl/mem_stage_lsu.sv | 122 ++++++++++++
 4 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// rtl/mem_stage_lsu_pkg.sv - opcodes, LSU state encoding and decode helpers for the MEM-stage LSU
package mem_stage_lsu_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  function automatic logic op_is_load(logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic op_is_store(logic [5:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  // Byte accesses never fault; halves need an even address, words a multiple of four.
  function automatic logic op_aligned(logic [5:0] op, logic [1:0] off);
    case (op)
      OP_LW, OP_SW:          return off == 2'b00;
      OP_LH, OP_LHU, OP_SH:  return !off[0];
      default:               return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// rtl/mem_stage_lsu_if.sv - req/ack word-access data bus between the LSU (master) and memory (slave)
interface mem_stage_lsu_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_byte_lane.sv
// rtl/mem_byte_lane.sv - store byte-enable/lane replication and load byte/half select with extension
module mem_byte_lane
  import mem_stage_lsu_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] wsrc,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    be    = 4'b1111;
    wdata = wsrc;
    case (op)
      OP_SB: begin
        be    = 4'b0001 << off;
        wdata = {4{wsrc[7:0]}};
      end
      OP_SH: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wsrc[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (off)
      2'd0:    rbyte = rword[7:0];
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
    rhalf = off[1] ? rword[31:16] : rword[15:0];
    case (op)
      OP_LB:   ldata = {{24{rbyte[7]}}, rbyte};
      OP_LBU:  ldata = {24'd0, rbyte};
      OP_LH:   ldata = {{16{rhalf[15]}}, rhalf};
      OP_LHU:  ldata = {16'd0, rhalf};
      default: ldata = rword;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit: decode, req/ack bus access, stall, timeout, misalign traps
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
)
(
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     mem_instr,
  input  logic [31:0]     mem_addr,
  input  logic [31:0]     mem_wdata,
  input  logic [31:0]     mem_pc,
  mem_stage_lsu_if.master bus,
  output logic            stall,
  output logic [31:0]     load_data,
  output logic            load_vld,
  output logic            adel,
  output logic            ades,
  output logic            bus_err,
  output logic [31:0]     exc_pc
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  lsu_state_e  state;
  logic [15:0] req_cnt;
  logic [5:0]  op, op_q, lane_op;
  logic [1:0]  off_q, lane_off;
  logic        mem_op, store, aligned, start;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_ldata;
  logic        unused_instr;

  assign op           = mem_instr[31:26];
  assign unused_instr = ^mem_instr[25:0];
  assign store        = op_is_store(op);
  assign mem_op       = store || op_is_load(op);
  assign aligned      = op_aligned(op, mem_addr[1:0]);
  assign start        = (state == IDLE) && mem_op && aligned;

  // The first stall cycle is the decode cycle itself, so this path must stay combinational.
  assign stall = !reset && (start || state == REQ);

  // Once the access is issued, extension uses the captured opcode/offset rather than EX/MEM.
  assign lane_op  = (state == IDLE) ? op : op_q;
  assign lane_off = (state == IDLE) ? mem_addr[1:0] : off_q;

  mem_byte_lane u_lane (
    .op    (lane_op),
    .off   (lane_off),
    .wsrc  (mem_wdata),
    .rword (bus.bus_rdata),
    .be    (lane_be),
    .wdata (lane_wdata),
    .ldata (lane_ldata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      req_cnt       <= '0;
      op_q          <= '0;
      off_q         <= '0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= '0;
      bus.bus_wdata <= '0;
      load_data     <= '0;
      load_vld      <= 1'b0;
      adel          <= 1'b0;
      ades          <= 1'b0;
      bus_err       <= 1'b0;
      exc_pc        <= '0;
    end else begin
      load_vld <= 1'b0;
      adel     <= 1'b0;
      ades     <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= store;
            bus.bus_addr  <= {mem_addr[31:2], 2'b00};
            bus.bus_be    <= lane_be;
            bus.bus_wdata <= lane_wdata;
            op_q          <= op;
            off_q         <= mem_addr[1:0];
            req_cnt       <= '0;
            state         <= REQ;
          end else if (mem_op) begin
            adel   <= !store;
            ades   <= store;
            exc_pc <= mem_pc;
          end
        end
        REQ: begin
          if (bus.bus_ack) begin
            bus.bus_req <= 1'b0;
            if (!bus.bus_we) load_data <= lane_ldata;
            load_vld <= !bus.bus_we;
            state    <= DONE;
          end else if (req_cnt == TO_LAST) begin
            bus.bus_req <= 1'b0;
            bus_err     <= 1'b1;
            exc_pc      <= mem_pc;
            load_data   <= '0;
            load_vld    <= !bus.bus_we;
            state       <= DONE;
          end else if (req_cnt != 16'hFFFF) begin
            req_cnt <= req_cnt + 16'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
